// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Define PARITY_EN to insert the parity bit and enable parity_err.
module serial_frame_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

`ifdef PARITY_EN
  logic perr;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_mismatch(input logic par_bit, input logic [WIDTH-1:0] word);
    return par_bit ^ (^word);
  endfunction
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_EN
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;

      if (din_en) begin
        case (state)
          IDLE: begin
            if (!din) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shreg[cnt] <= din;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef PARITY_EN
          PARITY: begin
            perr  <= parity_mismatch(din, shreg);
            state <= STOP;
          end
`endif
          STOP: begin
            // The stop-bit strobe always ends the frame; a low stop bit is never a new start.
            state <= IDLE;
            busy  <= 1'b0;
            if (!din)
              frame_err <= 1'b1;
`ifdef PARITY_EN
            else if (perr)
              parity_err <= 1'b1;
`endif
            else if (!dout_valid || dout_ready) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
            end else
              overrun <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
